// File: rtl/twos_complement_to_bcd.sv
// twos_complement_to_bcd
// Converts a (bits+1)-bit two's-complement operand to sign, widened magnitude
// and packed BCD using a one-bit-per-clock shift-add-3 engine.
// Optional feature macro: TWOS_BCD_BLANK_EN (adds the blankMask output).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   twosComp, inValid   operand and its valid; inReady high only while idle
//   sign, magnitude     result sign (1 = negative) and absolute value
//   bcd                 packed BCD, digit 0 in bcd[3:0]
//   outValid, outReady  result handshake
//   blankMask           leading-zero blanking per digit (macro only)
module twos_complement_to_bcd #(
    parameter int unsigned bits   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [bits:0]         twosComp,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  sign,
    output logic [bits:0]         magnitude,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  outValid,
    input  logic                  outReady
`ifdef TWOS_BCD_BLANK_EN
   ,output logic [DIGITS-1:0]     blankMask
`endif
);

    localparam int unsigned W     = bits + 1;
    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(bits + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               sign_q, sign_d;
    logic [W-1:0]       mag_q, mag_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               sign_cap_q, sign_cap_d;
    logic [W-1:0]       mag_cap_q, mag_cap_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [W-1:0]       sh_shift;
    logic               accept;
    logic               last_step;

    assign accept    = (state_q == IDLE) && inValid;
    assign last_step = (state_q == CONV) && (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CONV;
            CONV:    if (last_step) state_d = DONE;
            DONE:    if (outReady)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Shift-add-3 step: correct digits >= 5, then shift {acc, shreg} left
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_shift = {acc_adj[ACC_W-2:0], shreg_q[W-1]};
        sh_shift  = {shreg_q[W-2:0], 1'b0};
    end

    // Output and datapath next values
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        sign_d      = sign_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        sign_cap_d  = sign_cap_q;
        mag_cap_d   = mag_cap_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (accept) begin
            sign_cap_d = twosComp[bits];
            mag_cap_d  = twosComp[bits] ? W'(~twosComp + 1'b1) : twosComp;
            shreg_d    = twosComp[bits] ? W'(~twosComp + 1'b1) : twosComp;
            acc_d      = '0;
            cnt_d      = CNT_W'(W);
        end else if (state_q == CONV) begin
            acc_d   = acc_shift;
            shreg_d = sh_shift;
            cnt_d   = cnt_q - CNT_W'(1);
            // Results are published only on entry to DONE so they hold between conversions
            if (last_step) begin
                sign_d = sign_cap_q;
                mag_d  = mag_cap_q;
                bcd_d  = acc_shift;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            sign_cap_q  <= 1'b0;
            mag_cap_q   <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            sign_cap_q  <= sign_cap_d;
            mag_cap_q   <= mag_cap_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign inReady   = in_ready_q;
    assign outValid  = out_valid_q;
    assign sign      = sign_q;
    assign magnitude = mag_q;
    assign bcd       = bcd_q;

`ifdef TWOS_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              upper_zero;

    // Digit i blanks when it and every higher digit are zero; digit 0 never blanks
    always_comb begin
        blank_d    = blank_q;
        upper_zero = 1'b1;
        if (last_step) begin
            blank_d = '0;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                upper_zero = upper_zero & (acc_shift[4*i +: 4] == 4'd0);
                blank_d[i] = upper_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) blank_q <= '0;
        else        blank_q <= blank_d;
    end

    assign blankMask = blank_q;
`endif

endmodule

// File: tb/tb_twos_complement_to_bcd.sv
// Directed bench for twos_complement_to_bcd (bits=8, DIGITS=3).
module tb_twos_complement_to_bcd;

    logic        clk;
    logic        rst_n;
    logic [8:0]  twosComp;
    logic        inValid;
    logic        inReady;
    logic        sign;
    logic [8:0]  magnitude;
    logic [11:0] bcd;
    logic        outValid;
    logic        outReady;
`ifdef TWOS_BCD_BLANK_EN
    logic [2:0]  blankMask;
`endif

    int n_checks;
    int n_fail;

    twos_complement_to_bcd #(.bits(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .twosComp  (twosComp),
        .inValid   (inValid),
        .inReady   (inReady),
        .sign      (sign),
        .magnitude (magnitude),
        .bcd       (bcd),
        .outValid  (outValid),
        .outReady  (outReady)
`ifdef TWOS_BCD_BLANK_EN
       ,.blankMask (blankMask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  32'(inReady),   32'd1);
        check({tag, "_out_valid"}, 32'(outValid),  32'd0);
        check({tag, "_sign"},      32'(sign),      32'd0);
        check({tag, "_magnitude"}, 32'(magnitude), 32'd0);
        check({tag, "_bcd"},       32'(bcd),       32'd0);
`ifdef TWOS_BCD_BLANK_EN
        check({tag, "_blank"},     32'(blankMask), 32'd0);
`endif
    endtask

    task automatic check_result(input string tag, input logic exp_sign, input logic [8:0] exp_mag,
                                input logic [11:0] exp_bcd, input logic [2:0] exp_blank);
        check({tag, "_sign"},      32'(sign),      32'(exp_sign));
        check({tag, "_magnitude"}, 32'(magnitude), 32'(exp_mag));
        check({tag, "_bcd"},       32'(bcd),       32'(exp_bcd));
`ifdef TWOS_BCD_BLANK_EN
        check({tag, "_blank"},     32'(blankMask), 32'(exp_blank));
`else
        if (exp_blank === 3'bxxx) check({tag, "_blank_arg"}, 32'(exp_blank), 32'd0);
`endif
    endtask

    // One conversion: accept, latency, optional stall on the output, handshake
    task automatic convert(input string tag, input logic [8:0] v, input logic exp_sign,
                           input logic [8:0] exp_mag, input logic [11:0] exp_bcd,
                           input logic [2:0] exp_blank, input bit scramble, input bit hold);
        int lat;
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(inReady), 32'd1);
        twosComp = v;
        inValid  = 1'b1;
        outReady = !hold;
        @(posedge clk); #1;
        check({tag, "_accept_ready_low"}, 32'(inReady), 32'd0);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(negedge clk);
            if (scramble) begin
                twosComp = 9'($urandom);
                inValid  = 1'($urandom);
            end else begin
                inValid  = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check_result(tag, exp_sign, exp_mag, exp_bcd, exp_blank);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                if (scramble) twosComp = 9'($urandom);
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 32'(outValid), 32'd1);
                check({tag, "_hold_ready"}, 32'(inReady),  32'd0);
                check({tag, "_hold_bcd"},   32'(bcd),      32'(exp_bcd));
            end
            @(negedge clk);
            outReady = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_post_valid"}, 32'(outValid), 32'd0);
        check({tag, "_post_ready"}, 32'(inReady),  32'd1);
        check_result({tag, "_post"}, exp_sign, exp_mag, exp_bcd, exp_blank);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        twosComp = 9'h000;
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        convert("pos37",  9'h025, 1'b0, 9'd37,  12'h037, 3'b100, 1'b0, 1'b0);
        convert("neg1",   9'h1FF, 1'b1, 9'd1,   12'h001, 3'b110, 1'b0, 1'b0);
        convert("minneg", 9'h100, 1'b1, 9'd256, 12'h256, 3'b000, 1'b0, 1'b0);
        convert("max255", 9'h0FF, 1'b0, 9'd255, 12'h255, 3'b000, 1'b0, 1'b0);
        convert("zero",   9'h000, 1'b0, 9'd0,   12'h000, 3'b110, 1'b0, 1'b1);

        // Reset in the middle of a conversion discards it
        @(negedge clk);
        twosComp = 9'h1C8;
        inValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            check("midreset_no_valid", 32'(outValid), 32'd0);
        end

        convert("after_rst", 9'h001, 1'b0, 9'd1,   12'h001, 3'b110, 1'b0, 1'b0);
        convert("scr_neg100", 9'h19C, 1'b1, 9'd100, 12'h100, 3'b000, 1'b1, 1'b1);
        convert("scr_neg56",  9'h1C8, 1'b1, 9'd56,  12'h056, 3'b100, 1'b1, 1'b0);
        convert("pos10",      9'h00A, 1'b0, 9'd10,  12'h010, 3'b100, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
